// File: rtl/rr_tenure_scheduler_if.sv
// Request/grant bundle between requesters (master side) and the tenure scheduler (slave side).
// rel carries the per-requester end-of-tenure pulses.
interface rr_tenure_scheduler_if #(
  parameter int NREQ = 4
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] rel;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic            preempt;

  modport master (
    output req, rel,
    input  gnt, gnt_id, busy, preempt
  );

  modport slave (
    input  req, rel,
    output gnt, gnt_id, busy, preempt
  );
endinterface

// File: rtl/rr_tenure_scheduler.sv
// Round-robin scheduler that grants a shared resource for a multi-cycle tenure,
// ended by owner release, owner dropping req, or a bounded hold timer.
//
// state     | meaning
// S_IDLE    | no owner; arbitrate among req starting at ptr
// S_GRANT   | one owner holds gnt; hold timer running
// S_RECOVER | one-cycle gap after a tenure; preempt visible if it timed out
module rr_tenure_scheduler #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_tenure_scheduler_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(HOLD_MAX);
  localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_MAX - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RECOVER
  } state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt, gnt_nxt;
  logic [IDW-1:0]  gnt_id, gnt_id_nxt;
  logic            busy, busy_nxt;
  logic            preempt, preempt_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic            owner_end;
  logic            others_wait;

  // Scan from the highest offset down so the last hit is the first set bit at/after ptr.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[(int'(ptr) + i) % NREQ]) begin
        win_found = 1'b1;
        win_id    = IDW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  assign owner_end   = bus.rel[gnt_id] || !bus.req[gnt_id];
  assign others_wait = |(bus.req & ~gnt);

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    busy_nxt    = busy;
    preempt_nxt = 1'b0;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          gnt_nxt         = '0;
          gnt_nxt[win_id] = 1'b1;
          gnt_id_nxt      = win_id;
          busy_nxt        = 1'b1;
          cnt_nxt         = '0;
          ptr_nxt         = (win_id == ID_LAST) ? '0 : win_id + 1'b1;
          state_nxt       = S_GRANT;
        end
      end
      S_GRANT: begin
        if (owner_end) begin
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = S_RECOVER;
        end else if (cnt == CNT_LAST && others_wait) begin
          gnt_nxt     = '0;
          busy_nxt    = 1'b0;
          preempt_nxt = 1'b1;
          state_nxt   = S_RECOVER;
        end else if (cnt != CNT_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RECOVER: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      preempt <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_id  <= gnt_id_nxt;
      busy    <= busy_nxt;
      preempt <= preempt_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.gnt_id  = gnt_id;
  assign bus.busy    = busy;
  assign bus.preempt = preempt;
endmodule

// File: tb/tb_rr_tenure_scheduler.sv
// Directed bench for rr_tenure_scheduler (NREQ=4, HOLD_MAX=16): vector table plus
// hand sequences for timeout, saturation, simultaneous end and mid-tenure reset.
module tb_rr_tenure_scheduler;
  logic clk;
  logic rst;

  rr_tenure_scheduler_if #(.NREQ(4)) bus ();

  rr_tenure_scheduler #(.NREQ(4), .HOLD_MAX(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst_before;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       pre;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(bit rb, logic [3:0] r, logic [3:0] l, logic [3:0] g,
                              logic [1:0] id, logic b, logic p);
    vec_t v;
    v.rst_before = rb; v.req = r; v.rel = l; v.gnt = g; v.id = id; v.busy = b; v.pre = p;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] l);
    bus.req = r;
    bus.rel = l;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.rel = '0;
    rst = 1'b0;
    #3;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_id", 32'(bus.gnt_id), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_preempt", 32'(bus.preempt), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int good;
    rst = 1'b0;
    bus.req = '0;
    bus.rel = '0;

    // single requester: grant at edge 2, release at edge 5, then idle
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    // rotation with req=1111 from a fresh reset; release 3 edges after each grant
    for (int o = 0; o < 4; o++) begin
      logic [3:0] oh;
      oh = 4'b0001 << o;
      add(o == 0, 4'hF, 4'h0, oh, 2'(o), 1, 0);
      add(0, 4'hF, 4'h0, oh, 2'(o), 1, 0);
      add(0, 4'hF, 4'h0, oh, 2'(o), 1, 0);
      add(0, 4'hF, oh, 4'h0, 2'(o), 0, 0);
      add(0, 4'hF, 4'h0, 4'h0, 2'(o), 0, 0);
    end
    add(0, 4'hF, 4'h0, 4'b0001, 2'd0, 1, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      step(vecs[i].req, vecs[i].rel);
      check($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_id", i), 32'(bus.gnt_id), 32'(vecs[i].id));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_pre", i), 32'(bus.preempt), 32'(vecs[i].pre));
    end

    // timeout: owner 0 holds exactly 16 cycles, preempt for one, owner 1 two edges later
    do_reset();
    good = 0;
    for (int i = 0; i < 16; i++) begin
      step(4'b0011, 4'b0000);
      if (bus.gnt == 4'b0001 && bus.busy && !bus.preempt) good++;
    end
    check("to_hold_cycles", 32'(good), 16);
    step(4'b0011, 4'b0000);
    check("to_gnt_clear", 32'(bus.gnt), 0);
    check("to_preempt", 32'(bus.preempt), 1);
    step(4'b0011, 4'b0000);
    check("to_gap_gnt", 32'(bus.gnt), 0);
    check("to_preempt_drop", 32'(bus.preempt), 0);
    step(4'b0011, 4'b0000);
    check("to_next_gnt", 32'(bus.gnt), 32'h2);
    check("to_next_id", 32'(bus.gnt_id), 1);

    // lone owner never preempted; saturated timer fires at once when a rival appears
    do_reset();
    step(4'b0100, 4'b0000);
    check("lone_gnt", 32'(bus.gnt), 32'h4);
    good = 0;
    for (int i = 0; i < 99; i++) begin
      step(4'b0100, 4'b0000);
      if (bus.gnt == 4'b0100 && bus.busy && !bus.preempt) good++;
    end
    check("lone_hold", 32'(good), 99);
    step(4'b1100, 4'b0000);
    check("lone_sat_gnt", 32'(bus.gnt), 0);
    check("lone_sat_preempt", 32'(bus.preempt), 1);

    // non-owner release ignored; owner drop at cnt==15 beats the timeout
    do_reset();
    step(4'b0100, 4'b0000);
    check("sim_gnt", 32'(bus.gnt), 32'h4);
    check("sim_id", 32'(bus.gnt_id), 2);
    step(4'b1100, 4'b0010);
    check("sim_ign_rel", 32'(bus.gnt), 32'h4);
    good = 0;
    for (int i = 0; i < 14; i++) begin
      step(4'b1100, 4'b0000);
      if (bus.gnt == 4'b0100) good++;
    end
    check("sim_hold", 32'(good), 14);
    step(4'b1000, 4'b0000);
    check("sim_end_gnt", 32'(bus.gnt), 0);
    check("sim_end_preempt", 32'(bus.preempt), 0);
    check("sim_end_id", 32'(bus.gnt_id), 2);
    step(4'b1000, 4'b0000);
    check("sim_gap_preempt", 32'(bus.preempt), 0);
    step(4'b1000, 4'b0000);
    check("sim_next_gnt", 32'(bus.gnt), 32'h8);
    check("sim_next_id", 32'(bus.gnt_id), 3);

    // async reset mid-tenure, then arbitration restarts from ptr=0
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(bus.gnt), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_preempt", 32'(bus.preempt), 0);
    bus.req = 4'b1001;
    #2;
    rst = 1'b1;
    step(4'b1001, 4'b0000);
    check("post_rst_gnt", 32'(bus.gnt), 32'h1);
    check("post_rst_id", 32'(bus.gnt_id), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
